// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg
// Selects one of CANAIS valid/ready input channels (WIDTH bits each) and
// delivers the chosen word through a single registered output stage. Two
// selection modes: fixed (Seletor) and round-robin among channels with data.
//
// Optional feature macro: MUX_RR_CONTADOR_EN
//   When defined, adds a saturating 16-bit count of completed output
//   transfers (Contagem) and a synchronous clear input (Limpa).
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   Entradas     channel data, channel i at [i*WIDTH +: WIDTH]
//   Valido       per-channel valid
//   Pronto       per-channel ready (combinational, one-hot or zero)
//   Modo         0 = fixed selection by Seletor, 1 = round-robin
//   Seletor      channel index used in fixed mode
//   Saida        registered output word
//   SaidaValida  output register holds a word
//   SaidaPronto  consumer accepts the word
//   Canal        index of the channel that produced Saida
//   Contagem     (MUX_RR_CONTADOR_EN) completed output transfers, saturating
//   Limpa        (MUX_RR_CONTADOR_EN) synchronous clear of Contagem
// -----------------------------------------------------------------------------
module mux_rr_reg #(
  parameter int WIDTH  = 8,
  parameter int CANAIS = 8,
  localparam int SEL_W = $clog2(CANAIS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CANAIS*WIDTH-1:0]  Entradas,
  input  logic [CANAIS-1:0]        Valido,
  output logic [CANAIS-1:0]        Pronto,
  input  logic                     Modo,
  input  logic [SEL_W-1:0]         Seletor,
  output logic [WIDTH-1:0]         Saida,
  output logic                     SaidaValida,
  input  logic                     SaidaPronto,
  output logic [SEL_W-1:0]         Canal
`ifdef MUX_RR_CONTADOR_EN
  ,
  output logic [15:0]              Contagem,
  input  logic                     Limpa
`endif
);

  typedef enum logic [0:0] {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  estado_t            estado_r;
  logic [WIDTH-1:0]   saida_r;
  logic [SEL_W-1:0]   canal_r;
  logic [SEL_W-1:0]   ptr_r;

  logic               carrega_s;
  logic               sel_ok_s;
  logic               rr_ok_s;
  logic [SEL_W-1:0]   rr_idx_s;
  logic               grant_ok_s;
  logic [SEL_W-1:0]   grant_s;
  logic [WIDTH-1:0]   dado_s;
  logic               carga_s;
  logic               dreno_s;
  logic [SEL_W-1:0]   ptr_prox_s;

  // Channel index base+off folded back into 0..CANAIS-1. base is always a
  // legal index, so one subtraction is enough; this also keeps the wrap
  // correct when CANAIS is not a power of two.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                input int off);
    int soma;
    soma = int'(base) + off;
    return (soma >= CANAIS) ? SEL_W'(soma - CANAIS) : SEL_W'(soma);
  endfunction

  assign carrega_s = (estado_r == VAZIO) | SaidaPronto;

  // Fixed-mode request: Seletor must name an existing channel that is valid.
  always_comb begin
    sel_ok_s = 1'b0;
    for (int i = 0; i < CANAIS; i++) begin
      sel_ok_s = (Seletor == SEL_W'(i)) ? Valido[i] : sel_ok_s;
    end
  end

  // Round-robin search starting at ptr_r; scanning offsets from the far end
  // down lets the smallest offset with a valid channel win.
  always_comb begin
    rr_ok_s  = 1'b0;
    rr_idx_s = '0;
    for (int k = CANAIS - 1; k >= 0; k--) begin
      if (Valido[wrap_idx(ptr_r, k)]) begin
        rr_ok_s  = 1'b1;
        rr_idx_s = wrap_idx(ptr_r, k);
      end else begin
        rr_ok_s  = rr_ok_s;
        rr_idx_s = rr_idx_s;
      end
    end
  end

  assign grant_s    = Modo ? rr_idx_s : Seletor;
  assign grant_ok_s = Modo ? rr_ok_s  : sel_ok_s;
  assign carga_s    = carrega_s & grant_ok_s;
  assign dreno_s    = (estado_r == CHEIO) & SaidaPronto;
  assign ptr_prox_s = (grant_s == SEL_W'(CANAIS - 1)) ? '0 : grant_s + SEL_W'(1);

  // One-hot ready towards the granted channel; forced low while in reset.
  always_comb begin
    Pronto = '0;
    for (int i = 0; i < CANAIS; i++) begin
      Pronto[i] = rst_n & carga_s & (grant_s == SEL_W'(i));
    end
  end

  // Data multiplexer for the granted channel.
  always_comb begin
    dado_s = '0;
    for (int i = 0; i < CANAIS; i++) begin
      dado_s = (grant_s == SEL_W'(i)) ? Entradas[i*WIDTH +: WIDTH] : dado_s;
    end
  end

  // Output register FSM: load on input transfer, empty on a drain without reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= VAZIO;
      saida_r  <= '0;
      canal_r  <= '0;
    end else begin
      case (estado_r)
        VAZIO: begin
          if (carga_s) begin
            estado_r <= CHEIO;
            saida_r  <= dado_s;
            canal_r  <= grant_s;
          end
        end
        CHEIO: begin
          if (carga_s) begin
            estado_r <= CHEIO;
            saida_r  <= dado_s;
            canal_r  <= grant_s;
          end else if (dreno_s) begin
            estado_r <= VAZIO;
          end
        end
        default: begin
          estado_r <= VAZIO;
        end
      endcase
    end
  end

  // Round-robin pointer: moves past the served channel only in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (carga_s && Modo) begin
      ptr_r <= ptr_prox_s;
    end
  end

  assign Saida       = saida_r;
  assign SaidaValida = (estado_r == CHEIO);
  assign Canal       = canal_r;

`ifdef MUX_RR_CONTADOR_EN
  logic [15:0] contagem_r;

  // Saturating count of output transfers; Limpa wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem_r <= 16'h0000;
    end else if (Limpa) begin
      contagem_r <= 16'h0000;
    end else if (dreno_s && (contagem_r != 16'hFFFF)) begin
      contagem_r <= contagem_r + 16'h0001;
    end
  end

  assign Contagem = contagem_r;
`endif

endmodule
